// File: rtl/pixel_word_packer_if.sv
// Word write channel between the pixel packer and the ZBT write controller.
interface pixel_word_packer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pixel_word_packer.sv
// Packs four camera pixels into one 36-bit ZBT word and queues it behind a valid/ready FIFO.
// Optional binarization of pixels against THRESH: define PIXEL_WORD_PACKER_THRESHOLD_EN.
module pixel_word_packer #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  THRESH = 8'd128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic                   pixel_valid,
  input  logic [7:0]             pixel,
  pixel_word_packer_if.master    wr,
  output logic                   overflow,
  output logic [9:0]             x_out,
  output logic [9:0]             y_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [10:0]  x;
  logic [9:0]   y;
  logic [7:0]   p0, p1, p2;
  logic [10:0]  x_eff;
  logic [9:0]   y_eff;
  logic [1:0]   lane;
  logic [7:0]   pix_in;
  logic         accept, push, pop, wr_en, empty, full;
  logic [54:0]  mem [DEPTH];
  logic [54:0]  head;
  logic [AW:0]  wptr, rptr;

  // Counters as seen by a pixel arriving together with a frame/line start pulse
  always_comb begin
    x_eff = x;
    y_eff = y;
    if (frame_start) begin
      x_eff = '0;
      y_eff = '0;
    end else if (line_start) begin
      x_eff = '0;
      y_eff = (y == 10'd1023) ? y : y + 10'd1;
    end
  end

`ifdef PIXEL_WORD_PACKER_THRESHOLD_EN
  assign pix_in = (pixel >= THRESH) ? 8'hFF : 8'h00;
`else
  assign pix_in = pixel;
`endif

  assign lane   = x_eff[1:0];
  assign accept = pixel_valid && (x_eff < 11'(WIDTH)) && ({1'b0, y_eff} < 11'(HEIGHT));
  assign push   = accept && (lane == 2'd3);
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = !empty && wr.wr_ready;
  assign wr_en  = push && (!full || pop);
  assign head   = mem[rptr[AW-1:0]];

  assign wr.wr_valid = !empty;
  assign wr.wr_addr  = empty ? '0 : head[54:36];
  assign wr.wr_data  = empty ? '0 : head[35:0];
  assign x_out       = x[9:0];
  assign y_out       = y;

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      x <= x_eff + 11'(accept);
      y <= y_eff;
      if (frame_start || line_start) begin
        p0 <= '0;
        p1 <= '0;
        p2 <= '0;
      end
      if (accept) begin
        case (lane)
          2'd0:    p0 <= pix_in;
          2'd1:    p1 <= pix_in;
          2'd2:    p2 <= pix_in;
          default: ;
        endcase
      end
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= {1'b0, y_eff, x_eff[9:2], 4'b0, p0, p1, p2, pix_in};
        wptr <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      if (frame_start)
        overflow <= 1'b0;
      else if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer: packing, addressing, backpressure, bounds, reset.
module tb_pixel_word_packer;

  logic       clk = 1'b0;
  logic       reset, frame_start, line_start, pixel_valid;
  logic [7:0] pixel;
  logic       overflow;
  logic [9:0] x_out, y_out;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned base;

  logic [18:0] q_addr [$];
  logic [35:0] q_data [$];

  pixel_word_packer_if bus ();

  pixel_word_packer #(.WIDTH(640), .HEIGHT(480), .DEPTH(4), .THRESH(8'd128)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .wr          (bus.master),
    .overflow    (overflow),
    .x_out       (x_out),
    .y_out       (y_out)
  );

  always #5 clk = ~clk;

  // Log every accepted word in handshake order
  always @(posedge clk) begin
    if (!reset && bus.wr_valid && bus.wr_ready) begin
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] v);
    pixel_valid = 1'b1;
    pixel       = v;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic lstart();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    pixel_valid = 1'b0; pixel = '0; bus.wr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_addr",  64'(bus.wr_addr),  64'd0);
    chk("rst_data",  64'(bus.wr_data),  64'd0);
    chk("rst_ovf",   64'(overflow),     64'd0);
    chk("rst_xy",    {x_out, y_out},    64'd0);

    // Basic pack
    bus.wr_ready = 1'b1;
    fstart();
    base = q_addr.size();
    pix(8'h11); pix(8'h22); pix(8'h33);
    chk("basic_nowd", 64'(bus.wr_valid), 64'd0);
    pix(8'h44);
    chk("basic_valid", 64'(bus.wr_valid), 64'd1);
    chk("basic_data",  64'(bus.wr_data),  64'h0_11223344);
    chk("basic_addr",  64'(bus.wr_addr),  64'd0);
    chk("basic_x",     64'(x_out),        64'd4);
    tick();
    chk("basic_drop",  64'(bus.wr_valid), 64'd0);
    chk("basic_pops",  64'(q_addr.size() - base), 64'd1);

    // Line addressing
    fstart();
    for (int i = 0; i < 5; i++) lstart();
    chk("line_y", 64'(y_out), 64'd5);
    base = q_addr.size();
    for (int i = 0; i < 12; i++) pix(8'(i));
    tick(); tick();
    chk("line_pops", 64'(q_addr.size() - base), 64'd3);
    for (int k = 0; k < 3; k++)
      chk("line_addr", 64'(q_addr[base + k]), 64'({1'b0, 10'd5, 8'(k)}));
    chk("line_data2", 64'(q_data[base + 2]), 64'h0_08090A0B);

    // Backpressure and overflow
    bus.wr_ready = 1'b0;
    fstart();
    for (int i = 0; i < 16; i++) pix(8'(i));
    chk("bp_noovf", 64'(overflow), 64'd0);
    for (int i = 16; i < 20; i++) pix(8'(i));
    chk("bp_ovf",   64'(overflow),     64'd1);
    chk("bp_valid", 64'(bus.wr_valid), 64'd1);
    tick();
    chk("bp_hold_addr", 64'(bus.wr_addr), 64'd0);
    chk("bp_hold_data", 64'(bus.wr_data), 64'h0_00010203);
    base = q_addr.size();
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_pops", 64'(q_addr.size() - base), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("bp_addr", 64'(q_addr[base + k]), 64'(k));
    chk("bp_data3",  64'(q_data[base + 3]), 64'h0_0C0D0E0F);
    chk("bp_empty",  64'(bus.wr_valid),     64'd0);
    chk("bp_sticky", 64'(overflow),         64'd1);
    fstart();
    chk("bp_clear",  64'(overflow),         64'd0);

    // Partial word, then a pixel arriving with line_start
    base = q_addr.size();
    for (int i = 1; i <= 6; i++) pix(8'(i));
    tick(); tick();
    chk("part_pops", 64'(q_addr.size() - base), 64'd1);
    line_start = 1'b1; pixel_valid = 1'b1; pixel = 8'hA0;
    tick();
    line_start = 1'b0; pixel_valid = 1'b0;
    chk("part_y", 64'(y_out), 64'd1);
    chk("part_x", 64'(x_out), 64'd1);
    pix(8'hA1); pix(8'hA2); pix(8'hA3);
    tick(); tick();
    chk("part_pops2", 64'(q_addr.size() - base), 64'd2);
    chk("part_addr",  64'(q_addr[base + 1]), 64'h00100);
    chk("part_data",  64'(q_data[base + 1]), 64'h0_A0A1A2A3);

    // Bounds: overlong line, then the line past the frame
    fstart();
    base = q_addr.size();
    for (int i = 0; i < 644; i++) pix(8'(i));
    tick(); tick();
    chk("bnd_words", 64'(q_addr.size() - base), 64'd160);
    chk("bnd_last",  64'(q_addr[q_addr.size() - 1]), 64'd159);
    chk("bnd_x",     64'(x_out), 64'd640);
    for (int i = 0; i < 480; i++) lstart();
    chk("bnd_y", 64'(y_out), 64'd480);
    base = q_addr.size();
    for (int i = 0; i < 4; i++) pix(8'hEE);
    tick(); tick();
    chk("bnd_nowords", 64'(q_addr.size() - base), 64'd0);
    chk("bnd_x0",      64'(x_out), 64'd0);

    // Pixel transform (binarized or passed through)
    bus.wr_ready = 1'b0;
    fstart();
    pix(8'h7F); pix(8'h80); pix(8'hFF); pix(8'h00);
`ifdef PIXEL_WORD_PACKER_THRESHOLD_EN
    chk("thr_data", 64'(bus.wr_data), 64'h0_00FFFF00);
`else
    chk("thr_data", 64'(bus.wr_data), 64'h0_7F80FF00);
`endif

    // Reset with a queued word and a partial word in flight
    pix(8'h01); pix(8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", 64'(bus.wr_valid), 64'd0);
    chk("mid_xy",    {x_out, y_out},    64'd0);
    bus.wr_ready = 1'b1;
    base = q_addr.size();
    pix(8'h55); pix(8'h66); pix(8'h77); pix(8'h88);
    chk("mid_data", 64'(bus.wr_data), 64'h0_55667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
